// File: rtl/ibus_stream_port_pkg.sv
// ibus_stream_port shared definitions.
// Register offsets, STATUS bit positions and io-bus widths.
package ibus_stream_port_pkg;

    localparam int ADR_W  = 18;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_LEVEL  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_off_e;

    localparam int ST_RX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_UDF   = 2;
    localparam int ST_TX_OVF   = 3;

endpackage

// File: rtl/ibus_stream_port_fifo.sv
// stream_fifo: synchronous FIFO with zeroed head when empty.
// A pop frees the slot a same-cycle push needs, so full push+pop is legal.
module stream_fifo #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic                  do_push;
    logic                  do_pop;

    // count never exceeds DEPTH, so its MSB alone marks full
    assign empty   = (count == '0);
    assign full    = count[DEPTH_LOG2];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rptr];

    // pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
            if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
            if (do_push && !do_pop)
                count <= count + (DEPTH_LOG2 + 1)'(1);
            else if (do_pop && !do_push)
                count <= count - (DEPTH_LOG2 + 1)'(1);
        end
    end

    // storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

endmodule

// File: rtl/ibus_stream_port.sv
// ibus_stream_port: io-bus responder bridging DATA to TX/RX stream FIFOs.
// Two-stage read pipe gives fixed 2-cycle latency; idle slots read as 0.
module ibus_stream_port
    import ibus_stream_port_pkg::*;
#(
    parameter logic [ADR_W-1:0] BASE_ADR   = 18'h00100,
    parameter int               DEPTH_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst_pipe,
    input  logic              ibus_ren,
    input  logic [ADR_W-1:0]  ibus_radr,
    output logic [DATA_W-1:0] ibus32_rdata,
    input  logic              ibus_wen,
    input  logic [ADR_W-1:0]  ibus_wadr,
    input  logic [DATA_W-1:0] ibus32_wdata,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);

    logic [ADR_W-1:0]    roff;
    logic [ADR_W-1:0]    woff;
    logic                rd_hit;
    logic                wr_hit;
    reg_off_e            rsel;
    reg_off_e            wsel;

    logic                tx_push;
    logic                tx_pop;
    logic                tx_empty;
    logic                tx_full;
    logic [DEPTH_LOG2:0] tx_count;

    logic                rx_push;
    logic                rx_pop;
    logic [DATA_W-1:0]   rx_head;
    logic                rx_empty;
    logic                rx_full;
    logic [DEPTH_LOG2:0] rx_count;

    logic                rx_udf;
    logic                tx_ovf;
    logic                udf_set;
    logic                ovf_set;
    logic                udf_clr;
    logic                ovf_clr;

    logic [DATA_W-1:0]   status;
    logic [DATA_W-1:0]   level;
    logic [DATA_W-1:0]   rd_val;
    logic [DATA_W-1:0]   s1_data;
    logic [DATA_W-1:0]   s2_data;

    // window decode: offset below 4 means in-window
    assign roff   = ibus_radr - BASE_ADR;
    assign woff   = ibus_wadr - BASE_ADR;
    assign rd_hit = ibus_ren & (roff[ADR_W-1:2] == '0);
    assign wr_hit = ibus_wen & (woff[ADR_W-1:2] == '0);
    assign rsel   = reg_off_e'(roff[1:0]);
    assign wsel   = reg_off_e'(woff[1:0]);

    assign tx_push = wr_hit & (wsel == REG_DATA);
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_pop  = rd_hit & (rsel == REG_DATA);
    assign rx_push = rx_valid & rx_ready;

    assign tx_valid = ~tx_empty;
    assign rx_ready = ~rx_full;

    // a same-cycle sink pop makes room, so only an unmatched full push drops
    assign udf_set = rx_pop & rx_empty;
    assign ovf_set = tx_push & tx_full & ~tx_pop;
    assign udf_clr = wr_hit & (wsel == REG_STATUS) & ibus32_wdata[ST_RX_UDF];
    assign ovf_clr = wr_hit & (wsel == REG_STATUS) & ibus32_wdata[ST_TX_OVF];

    stream_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (rst_pipe),
        .push      (tx_push),
        .push_data (ibus32_wdata),
        .pop       (tx_pop),
        .head      (tx_data),
        .empty     (tx_empty),
        .full      (tx_full),
        .count     (tx_count)
    );

    stream_fifo #(
        .WIDTH      (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (rst_pipe),
        .push      (rx_push),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .count     (rx_count)
    );

    // status and level words as seen during the request cycle
    always_comb begin
        status              = '0;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_UDF]   = rx_udf;
        status[ST_TX_OVF]   = tx_ovf;
        level               = {8'(tx_count), 8'(rx_count)};
    end

    // read source select; empty RX head already reads as 0
    always_comb begin
        rd_val = '0;
        unique case (rsel)
            REG_DATA:   rd_val = rx_head;
            REG_STATUS: rd_val = status;
            REG_LEVEL:  rd_val = level;
            default:    rd_val = '0;
        endcase
    end

    // sticky error flags, a set beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n || rst_pipe) begin
            rx_udf <= 1'b0;
            tx_ovf <= 1'b0;
        end else begin
            rx_udf <= udf_set | (rx_udf & ~udf_clr);
            tx_ovf <= ovf_set | (tx_ovf & ~ovf_clr);
        end
    end

    // two-stage read pipe; non-hit slots carry 0 for bus OR-ing
    always_ff @(posedge clk) begin
        if (!rst_n || rst_pipe) begin
            s1_data <= '0;
            s2_data <= '0;
        end else begin
            s1_data <= rd_hit ? rd_val : '0;
            s2_data <= s1_data;
        end
    end

    assign ibus32_rdata = s2_data;

endmodule
